// File: rtl/conv_enc_pkg.sv
// Shared definitions for the framed rate-1/2 convolutional encoder.
// The parity helper is the single definition of the generator convention
// (MSB of each generator taps the current input bit); the matching decoder
// branch-metric logic calls it as well.
package conv_enc_pkg;

    localparam int          K_DEF     = 3;
    localparam logic [2:0]  G0_DEF    = 3'b111;
    localparam logic [2:0]  G1_DEF    = 3'b101;
    localparam int          L_MAX_DEF = 4096;

    // Widest {b,sr} vector the parity helper accepts; narrower vectors are zero-extended.
    localparam int          VMAX      = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        TAIL  = 2'd2,
        DRAIN = 2'd3
    } enc_state_t;

    // Returns {c0,c1}: parity of v under generator 0 in bit1, generator 1 in bit0.
    function automatic logic [1:0] parity2(input logic [VMAX-1:0] v,
                                           input logic [VMAX-1:0] g0,
                                           input logic [VMAX-1:0] g1);
        return {^(v & g0), ^(v & g1)};
    endfunction

endpackage

// File: rtl/conv_enc_sym_gen.sv
// Combinational symbol generator: {b,sr} -> coded symbol and next shift register.
// sr holds the last K-1 inputs, newest at the MSB.
module conv_enc_sym_gen
    import conv_enc_pkg::*;
#(
    parameter int             K  = K_DEF,
    parameter logic [K-1:0]   G0 = G0_DEF,
    parameter logic [K-1:0]   G1 = G1_DEF
) (
    input  logic             bit_i,
    input  logic [K-2:0]     sr_i,
    output logic [1:0]       sym_o,
    output logic [K-2:0]     sr_next_o
);

    logic [K-1:0] v;

    assign v         = {bit_i, sr_i};
    assign sym_o     = parity2(VMAX'(v), VMAX'(G0), VMAX'(G1));
    // Dropping the oldest bit of v gives {b, sr[M-1:1]}, which also works for M=1.
    assign sr_next_o = v[K-1:1];

endmodule

// File: rtl/conv_encoder_framer.sv
// Framed rate-1/2 feed-forward convolutional encoder with a registered
// valid/ready symbol output (one symbol per cycle at full throughput).
// Build option: define CONV_ENC_TAIL_EN to append K-1 zero tail bits per
// frame so the encoder always finishes in state 0; without it the TAIL
// state has no logic and a frame emits exactly frame_len symbols.
module conv_encoder_framer
    import conv_enc_pkg::*;
#(
    parameter int             K     = K_DEF,
    parameter logic [K-1:0]   G0    = G0_DEF,
    parameter logic [K-1:0]   G1    = G1_DEF,
    parameter int             L_MAX = L_MAX_DEF,
    localparam int            LW    = $clog2(L_MAX + 1),
    localparam int            M     = K - 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             frame_start_i,
    input  logic [LW-1:0]    frame_len_i,
    input  logic             in_bit_i,
    input  logic             in_bit_valid_i,
    output logic             in_bit_ready_o,
    output logic [1:0]       tx_sym_o,
    output logic             tx_sym_valid_o,
    input  logic             tx_sym_ready_i,
    output logic             frame_busy_o,
    output logic             frame_done_o
);

    enc_state_t      state_q, state_d;
    logic [LW-1:0]   cnt_q;
    logic [M-1:0]    sr_q;
    logic [1:0]      sym_q;
    logic            sym_valid_q;
    logic            done_q;

    logic            out_free;
    logic            enc_fire;
    logic            enc_bit;
    logic            last_fire;
    logic [1:0]      sym_w;
    logic [M-1:0]    sr_next_w;

    conv_enc_sym_gen #(.K(K), .G0(G0), .G1(G1)) u_sym_gen (
        .bit_i     (enc_bit),
        .sr_i      (sr_q),
        .sym_o     (sym_w),
        .sr_next_o (sr_next_w)
    );

    // Output register can take a new symbol when empty or being drained this cycle.
    assign out_free  = !sym_valid_q || tx_sym_ready_i;
    // Last bit of the current phase is being encoded; lets the FSM move on without a bubble.
    assign last_fire = enc_fire && (cnt_q == LW'(1));

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; a phase ends when its count is exhausted or its last bit fires.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (frame_start_i) state_d = DATA;
`ifdef CONV_ENC_TAIL_EN
            DATA:  if (cnt_q == '0 || last_fire) state_d = TAIL;
            TAIL:  if (cnt_q == '0 || last_fire) state_d = DRAIN;
`else
            DATA:  if (cnt_q == '0 || last_fire) state_d = DRAIN;
`endif
            DRAIN: if (out_free) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/handshake decode: which bit (if any) enters the encoder this cycle.
    always_comb begin
        in_bit_ready_o = 1'b0;
        enc_fire       = 1'b0;
        enc_bit        = 1'b0;
        frame_busy_o   = (state_q != IDLE);
        case (state_q)
            DATA: begin
                in_bit_ready_o = (cnt_q != '0) && out_free;
                enc_fire       = in_bit_ready_o && in_bit_valid_i;
                enc_bit        = in_bit_i;
            end
`ifdef CONV_ENC_TAIL_EN
            TAIL: begin
                enc_fire = (cnt_q != '0) && out_free;
                enc_bit  = 1'b0;
            end
`endif
            default: ;
        endcase
    end

    // Datapath: shift register, bit counter, output symbol register and done pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            sr_q        <= '0;
            sym_q       <= 2'b00;
            sym_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= (state_q == DRAIN) && out_free;

            if (state_q == IDLE && frame_start_i) begin
                sr_q  <= '0;
                cnt_q <= (frame_len_i > LW'(L_MAX)) ? LW'(L_MAX) : frame_len_i;
            end else if (enc_fire) begin
                sr_q  <= sr_next_w;
                cnt_q <= cnt_q - LW'(1);
            end
`ifdef CONV_ENC_TAIL_EN
            // Reload the counter with the tail length on the DATA->TAIL step.
            if (state_q == DATA && state_d == TAIL) cnt_q <= LW'(M);
`endif

            if (enc_fire) begin
                sym_q       <= sym_w;
                sym_valid_q <= 1'b1;
            end else if (tx_sym_ready_i) begin
                sym_valid_q <= 1'b0;
            end
        end
    end

    assign tx_sym_o       = sym_q;
    assign tx_sym_valid_o = sym_valid_q;
    assign frame_done_o   = done_q;

endmodule

// File: tb/tb_conv_encoder_framer.sv
// Self-checking bench for conv_encoder_framer (K=3, G0=7, G1=5).
// Expected symbols come from a bench-side encoder written in terms of the
// two previous inputs (c0 = b^s1^s2, c1 = b^s2) and are queued at frame start,
// then popped as the DUT's symbols are accepted. Honours CONV_ENC_TAIL_EN.
module tb_conv_encoder_framer;

    localparam int K     = 3;
    localparam int M     = K - 1;
    localparam int L_MAX = 4096;
    localparam int LW    = $clog2(L_MAX + 1);
`ifdef CONV_ENC_TAIL_EN
    localparam bit TAIL_EN = 1'b1;
`else
    localparam bit TAIL_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            frame_start;
    logic [LW-1:0]   frame_len;
    logic            in_bit;
    logic            in_bit_valid;
    logic            in_bit_ready;
    logic [1:0]      tx_sym;
    logic            tx_sym_valid;
    logic            tx_sym_ready;
    logic            frame_busy;
    logic            frame_done;

    conv_encoder_framer #(.K(K), .G0(3'b111), .G1(3'b101), .L_MAX(L_MAX)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .frame_start_i  (frame_start),
        .frame_len_i    (frame_len),
        .in_bit_i       (in_bit),
        .in_bit_valid_i (in_bit_valid),
        .in_bit_ready_o (in_bit_ready),
        .tx_sym_o       (tx_sym),
        .tx_sym_valid_o (tx_sym_valid),
        .tx_sym_ready_i (tx_sym_ready),
        .frame_busy_o   (frame_busy),
        .frame_done_o   (frame_done)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic        bits [0:L_MAX-1];
    logic [1:0]  exp_q [$];
    int          done_cycle;
    int          acc_bits;
    int          got_syms;

    // Runs one frame: mode 0 = ready always high, 1 = ready toggles, 2 = random ready and valid gaps.
    task automatic run_frame(input int port_len, input int data_len, input int mode,
                             input bit inject_busy_start);
        logic       s1, s2, b;
        logic [1:0] prev_sym, e;
        logic       prev_stall;
        int         idx, budget;
        s1 = 1'b0; s2 = 1'b0;
        exp_q.delete();
        for (int i = 0; i < data_len + (TAIL_EN ? M : 0); i++) begin
            b = (i < data_len) ? bits[i] : 1'b0;
            exp_q.push_back({b ^ s1 ^ s2, b ^ s2});
            s2 = s1;
            s1 = b;
        end
        idx = 0; done_cycle = -1; got_syms = 0; prev_stall = 1'b0; prev_sym = 2'b00;
        budget = 6 * (data_len + M) + 40;
        for (int c = 0; c < budget && done_cycle < 0; c++) begin
            @(negedge clk);
            frame_start  = (c == 0) || (inject_busy_start && c == 5);
            frame_len    = (c == 0) ? LW'(port_len) : LW'(3);
            case (mode)
                0:       tx_sym_ready = 1'b1;
                1:       tx_sym_ready = (c % 2 == 0);
                default: tx_sym_ready = 1'($urandom_range(0, 1));
            endcase
            in_bit_valid = (idx < data_len) && (mode != 2 || $urandom_range(0, 3) != 0);
            in_bit       = (idx < data_len) ? bits[idx] : 1'b0;
            #1;
            if (frame_done) done_cycle = c;
            if (prev_stall) begin
                n_checks++;
                if (!tx_sym_valid || tx_sym !== prev_sym) begin
                    n_errors++;
                    $display("FAIL stall_hold c=%0d: got valid=%b sym=%b required valid=1 sym=%b",
                             c, tx_sym_valid, tx_sym, prev_sym);
                end
            end
            if (tx_sym_valid && !tx_sym_ready) begin
                n_checks++;
                if (in_bit_ready !== 1'b0) begin
                    n_errors++;
                    $display("FAIL stall_in_ready c=%0d: got %b required 0", c, in_bit_ready);
                end
            end
            prev_stall = tx_sym_valid && !tx_sym_ready;
            prev_sym   = tx_sym;
            if (tx_sym_valid && tx_sym_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL extra_sym c=%0d: got %b required no symbol", c, tx_sym);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_sym !== e) begin
                        n_errors++;
                        $display("FAIL sym_%0d: got %b required %b", got_syms, tx_sym, e);
                    end
                end
                got_syms++;
            end
            if (in_bit_valid && in_bit_ready) idx++;
        end
        acc_bits = idx;
        @(negedge clk);
        frame_start = 1'b0; in_bit_valid = 1'b0; tx_sym_ready = 1'b1;
        #1;
        n_checks++;
        if (done_cycle < 0) begin
            n_errors++;
            $display("FAIL frame_done_timeout: got no pulse within %0d cycles required a pulse", budget);
        end else if (frame_done !== 1'b0 || frame_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL done_pulse_width: got done=%b busy=%b required 0 0", frame_done, frame_busy);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL missing_syms: got %0d left required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; frame_start = 1'b0; frame_len = '0; in_bit = 1'b0;
        in_bit_valid = 1'b0; tx_sym_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({in_bit_ready, tx_sym, tx_sym_valid, frame_busy, frame_done} !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %b required 000000",
                     {in_bit_ready, tx_sym, tx_sym_valid, frame_busy, frame_done});
        end
        @(negedge clk);
        rst = 1'b0;
        // Valid bits while idle must be neither accepted nor start anything.
        in_bit_valid = 1'b1; in_bit = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (in_bit_ready !== 1'b0 || frame_busy !== 1'b0 || tx_sym_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL idle_ignore: got ready=%b busy=%b valid=%b required 0 0 0",
                         in_bit_ready, frame_busy, tx_sym_valid);
            end
        end
        in_bit_valid = 1'b0;
    endtask

    task automatic load_t1_bits();
        bits[0] = 1'b1; bits[1] = 1'b0; bits[2] = 1'b1; bits[3] = 1'b1;
    endtask

    task automatic test_known_vector();
        load_t1_bits();
        run_frame(4, 4, 0, 1'b0);
        n_checks++;
        if (got_syms != (TAIL_EN ? 6 : 4)) begin
            n_errors++;
            $display("FAIL t1_sym_count: got %0d required %0d", got_syms, TAIL_EN ? 6 : 4);
        end
        n_checks++;
        if (done_cycle != (TAIL_EN ? 8 : 6)) begin
            n_errors++;
            $display("FAIL t1_done_cycle: got %0d required %0d", done_cycle, TAIL_EN ? 8 : 6);
        end
        n_checks++;
        if (dut.sr_q !== (TAIL_EN ? 2'b00 : 2'b11)) begin
            n_errors++;
            $display("FAIL t2_final_sr: got %b required %b", dut.sr_q, TAIL_EN ? 2'b00 : 2'b11);
        end
    endtask

    task automatic test_backpressure();
        load_t1_bits();
        run_frame(4, 4, 1, 1'b0);
        n_checks++;
        if (got_syms != (TAIL_EN ? 6 : 4)) begin
            n_errors++;
            $display("FAIL t3_sym_count: got %0d required %0d", got_syms, TAIL_EN ? 6 : 4);
        end
    endtask

    task automatic test_zero_len();
        run_frame(0, 0, 0, 1'b0);
        n_checks++;
        if (got_syms != (TAIL_EN ? 2 : 0)) begin
            n_errors++;
            $display("FAIL t4_sym_count: got %0d required %0d", got_syms, TAIL_EN ? 2 : 0);
        end
        n_checks++;
        if (done_cycle != (TAIL_EN ? 5 : 3)) begin
            n_errors++;
            $display("FAIL t4_done_cycle: got %0d required %0d", done_cycle, TAIL_EN ? 5 : 3);
        end
    endtask

    task automatic test_clamp();
        for (int i = 0; i < L_MAX; i++) bits[i] = 1'($urandom_range(0, 1));
        run_frame(5000, L_MAX, 0, 1'b0);
        n_checks++;
        if (acc_bits != L_MAX) begin
            n_errors++;
            $display("FAIL clamp_bits: got %0d required %0d", acc_bits, L_MAX);
        end
    endtask

    task automatic test_mid_reset();
        int  idx;
        bit  seen_done;
        for (int i = 0; i < 256; i++) bits[i] = 1'($urandom_range(0, 1));
        bits[0] = 1'b1; bits[1] = 1'b1;
        idx = 0; seen_done = 1'b0;
        @(negedge clk);
        frame_start = 1'b1; frame_len = LW'(256); tx_sym_ready = 1'b1;
        for (int c = 0; c < 20 && idx < 2; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 1) frame_start = 1'b0;
            in_bit_valid = 1'b1; in_bit = bits[idx];
            #1;
            if (in_bit_valid && in_bit_ready) idx++;
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({in_bit_ready, tx_sym, tx_sym_valid, frame_busy, frame_done} !== 6'b0 || idx != 2) begin
            n_errors++;
            $display("FAIL mid_reset_outputs: got %b after %0d bits required 000000 after 2",
                     {in_bit_ready, tx_sym, tx_sym_valid, frame_busy, frame_done}, idx);
        end
        @(negedge clk);
        in_bit_valid = 1'b0; frame_start = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (frame_done || frame_busy) seen_done = 1'b1;
        end
        n_checks++;
        if (seen_done) begin
            n_errors++;
            $display("FAIL mid_reset_no_done: got done/busy activity required none");
        end
        load_t1_bits();
        run_frame(4, 4, 0, 1'b0);
        n_checks++;
        if (got_syms != (TAIL_EN ? 6 : 4)) begin
            n_errors++;
            $display("FAIL t5_rerun_count: got %0d required %0d", got_syms, TAIL_EN ? 6 : 4);
        end
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 10; f++) begin
            for (int i = 0; i < 256; i++) bits[i] = 1'($urandom_range(0, 1));
            run_frame(256, 256, 2, 1'b1);
            n_checks++;
            if (acc_bits != 256 || got_syms != 256 + (TAIL_EN ? M : 0)) begin
                n_errors++;
                $display("FAIL t6_frame_%0d: got bits=%0d syms=%0d required 256 %0d",
                         f, acc_bits, got_syms, 256 + (TAIL_EN ? M : 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_known_vector();
        test_backpressure();
        test_zero_len();
        test_mid_reset();
        test_random_frames();
        test_clamp();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
